// File: rtl/mem_debug_dumper_if.sv
// Bundles the dumper's bus signals: start/status, memory debug read port and UART TX handshake.
// The dumper takes the master side; the memory/UART/host environment takes the slave side.
interface mem_debug_dumper_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        debug_on;
   logic [31:0] debug_addr;
   logic [31:0] debug_data;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;

   modport master (
      input  start, debug_data, tx_busy,
      output busy, done, debug_on, debug_addr, tx_data, tx_start
   );

   modport slave (
      output start, debug_data, tx_busy,
      input  busy, done, debug_on, debug_addr, tx_data, tx_start
   );
endinterface

// File: rtl/mem_debug_dumper.sv
// Walks every data-memory word through its debug read port and streams each word,
// MSB byte first, to the UART transmitter with a start/busy handshake.
module mem_debug_dumper #(
   parameter int MEM_DEPTH = 32,
   parameter int RD_LAT    = 1
) (
   input  logic               clk,
   input  logic               rst,
   mem_debug_dumper_if.master dbg
);
   localparam int WC_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int LAT_W = $clog2(RD_LAT + 1);
   localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(MEM_DEPTH - 1);
   localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(RD_LAT);

   typedef enum logic [3:0] {
      IDLE, ADDR, WAIT, CAPTURE, SEND, ACK, DRAIN, NEXT, DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [WC_W-1:0]   word_cnt_reg, word_cnt_next;
   logic [1:0]        byte_idx_reg, byte_idx_next;
   logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
   logic [31:0]       capture_reg, capture_next;
   logic [31:0]       debug_addr_reg, debug_addr_next;
   logic [7:0]        tx_data_reg, tx_data_next;
   logic              tx_start_reg, tx_start_next;
   logic              debug_on_reg, debug_on_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;

   // Byte lanes of the captured word, lane 0 being the most significant byte.
   logic [7:0] lane [4];
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = capture_reg[8*(3-gi) +: 8];
   end

   assign dbg.debug_on   = debug_on_reg;
   assign dbg.debug_addr = debug_addr_reg;
   assign dbg.tx_data    = tx_data_reg;
   assign dbg.tx_start   = tx_start_reg;
   assign dbg.busy       = busy_reg;
   assign dbg.done       = done_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         word_cnt_reg   <= '0;
         byte_idx_reg   <= '0;
         lat_cnt_reg    <= '0;
         capture_reg    <= '0;
         debug_addr_reg <= '0;
         tx_data_reg    <= '0;
         tx_start_reg   <= 1'b0;
         debug_on_reg   <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         word_cnt_reg   <= word_cnt_next;
         byte_idx_reg   <= byte_idx_next;
         lat_cnt_reg    <= lat_cnt_next;
         capture_reg    <= capture_next;
         debug_addr_reg <= debug_addr_next;
         tx_data_reg    <= tx_data_next;
         tx_start_reg   <= tx_start_next;
         debug_on_reg   <= debug_on_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      word_cnt_next   = word_cnt_reg;
      byte_idx_next   = byte_idx_reg;
      lat_cnt_next    = lat_cnt_reg;
      capture_next    = capture_reg;
      debug_addr_next = debug_addr_reg;
      tx_data_next    = tx_data_reg;
      tx_start_next   = 1'b0;
      debug_on_next   = debug_on_reg;
      busy_next       = busy_reg;
      done_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (dbg.start) begin
               state_next    = ADDR;
               word_cnt_next = '0;
               debug_on_next = 1'b1;
               busy_next     = 1'b1;
            end
         end
         ADDR: begin
            debug_addr_next = 32'(word_cnt_reg);
            lat_cnt_next    = LAT_LOAD;
            state_next      = WAIT;
         end
         WAIT: begin
            // The decrement that reaches zero is the last wait cycle.
            lat_cnt_next = lat_cnt_reg - LAT_W'(1);
            if (lat_cnt_reg == LAT_W'(1)) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            capture_next  = dbg.debug_data;
            byte_idx_next = 2'd0;
            state_next    = SEND;
         end
         SEND: begin
            if (!dbg.tx_busy) begin
               tx_data_next  = lane[byte_idx_reg];
               tx_start_next = 1'b1;
               state_next    = ACK;
            end
         end
         ACK: begin
            if (dbg.tx_busy) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!dbg.tx_busy) begin
               if (byte_idx_reg == 2'd3) begin
                  state_next = NEXT;
               end else begin
                  byte_idx_next = byte_idx_reg + 2'd1;
                  state_next    = SEND;
               end
            end
         end
         NEXT: begin
            if (word_cnt_reg == LAST_WORD) begin
               done_next  = 1'b1;
               state_next = DONE;
            end else begin
               word_cnt_next = word_cnt_reg + WC_W'(1);
               state_next    = ADDR;
            end
         end
         DONE: begin
            debug_on_next = 1'b0;
            busy_next     = 1'b0;
            state_next    = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_mem_debug_dumper.sv
// Scoreboard bench: a 32-word/RD_LAT=1 dumper and a 4-word/RD_LAT=3 dumper, each with
// a memory model and a UART model that stays busy for 10 cycles per byte.
module tb_mem_debug_dumper;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_debug_dumper_if ifa ();
   mem_debug_dumper_if ifb ();

   mem_debug_dumper #(.MEM_DEPTH(32), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .dbg(ifa.master));
   mem_debug_dumper #(.MEM_DEPTH(4),  .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .dbg(ifb.master));

   logic [31:0] mem_a [32];
   logic [31:0] mem_b [4];
   logic [31:0] pipe_b [2];
   int          ucnt_a = 0;
   int          ucnt_b = 0;
   logic        hold_busy = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  sb_q [$];

   // Memory models: A returns data one posedge after the address, B three.
   always @(posedge clk) begin
      ifa.debug_data <= mem_a[ifa.debug_addr[4:0]];
      pipe_b[0]      <= mem_b[ifb.debug_addr[1:0]];
      pipe_b[1]      <= pipe_b[0];
      ifb.debug_data <= pipe_b[1];
      if (ifa.tx_start && ucnt_a == 0) ucnt_a <= 10;
      else if (ucnt_a != 0)            ucnt_a <= ucnt_a - 1;
      if (ifb.tx_start && ucnt_b == 0) ucnt_b <= 10;
      else if (ucnt_b != 0)            ucnt_b <= ucnt_b - 1;
   end

   assign ifa.tx_busy = (ucnt_a != 0) || hold_busy;
   assign ifb.tx_busy = (ucnt_b != 0);

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) ifa.start = v;
      else          ifb.start = v;
   endtask

   // Runs one dump on instance sel, checking every byte against the scoreboard.
   // hold_cycles>0 holds tx_busy from the start; poke_word>=0 re-pulses start at that word;
   // rst_byte>=0 applies a one-posedge reset right after that byte index is sent.
   task automatic run_dump(input int sel, input int hold_cycles, input int poke_word,
                           input int rst_byte, input string tag);
      int          depth, nbytes, ndone, cyc, stable, extra;
      logic        poked, prev_start, aborted, start_v;
      logic [31:0] prev_addr, s_addr;
      logic        s_start, s_done, s_busy, s_on;
      logic [7:0]  s_data, exp_b;
      depth = (sel == 0) ? 32 : 4;
      sb_q.delete();
      for (int w = 0; w < depth; w++) begin
         logic [31:0] word;
         word = (sel == 0) ? mem_a[w[4:0]] : mem_b[w[1:0]];
         for (int b = 0; b < 4; b++) sb_q.push_back(word[8*(3-b) +: 8]);
      end
      nbytes = 0; ndone = 0; cyc = 0; stable = 0; extra = 0;
      poked = 1'b0; prev_start = 1'b0; aborted = 1'b0; prev_addr = '0;
      hold_busy = (hold_cycles > 0);
      @(negedge clk);
      set_start(sel, 1'b1);
      while (ndone == 0 && cyc < 5000 && !aborted) begin
         @(negedge clk);
         cyc++;
         if (sel == 0) begin
            s_start = ifa.tx_start; s_data = ifa.tx_data; s_addr = ifa.debug_addr;
            s_done = ifa.done; s_busy = ifa.busy; s_on = ifa.debug_on;
         end else begin
            s_start = ifb.tx_start; s_data = ifb.tx_data; s_addr = ifb.debug_addr;
            s_done = ifb.done; s_busy = ifb.busy; s_on = ifb.debug_on;
         end
         if (s_addr == prev_addr) stable++;
         else stable = 0;
         prev_addr = s_addr;
         if (s_start) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_byte: tx_data=%02h, required no further byte", tag, s_data);
            end else begin
               exp_b = sb_q.pop_front();
               if (s_data !== exp_b) begin
                  errors++;
                  $display("FAIL %s byte%0d: tx_data=%02h, required %02h", tag, nbytes, s_data, exp_b);
               end
            end
            checks++;
            if (s_addr !== 32'(nbytes / 4)) begin
               errors++;
               $display("FAIL %s addr%0d: debug_addr=%0d, required %0d", tag, nbytes, s_addr, nbytes / 4);
            end
            checks++;
            if (prev_start !== 1'b0 || s_on !== 1'b1 || s_busy !== 1'b1) begin
               errors++;
               $display("FAIL %s flags%0d: prev_tx_start=%b debug_on=%b busy=%b, required 0 1 1",
                        tag, nbytes, prev_start, s_on, s_busy);
            end
            if (sel == 1 && nbytes % 4 == 0) begin
               checks++;
               if (stable < 3) begin
                  errors++;
                  $display("FAIL %s addr_stable%0d: %0d cycles, required >= 3", tag, nbytes, stable);
               end
            end
            $display("[%s] byte %0d addr %0d data %02h", tag, nbytes, s_addr, s_data);
            nbytes++;
            if (rst_byte >= 0 && nbytes == rst_byte + 1) begin
               rst = 1'b0;
               @(negedge clk);
               rst = 1'b1;
               checks++;
               if (ifa.debug_on !== 1'b0 || ifa.busy !== 1'b0 || ifa.tx_start !== 1'b0 ||
                   ifa.done !== 1'b0 || ifa.debug_addr !== 32'd0) begin
                  errors++;
                  $display("FAIL %s mid_reset: debug_on=%b busy=%b tx_start=%b done=%b addr=%0d, required 0 0 0 0 0",
                           tag, ifa.debug_on, ifa.busy, ifa.tx_start, ifa.done, ifa.debug_addr);
               end
               aborted = 1'b1;
            end
         end
         if (s_done) ndone++;
         prev_start = s_start;
         if (hold_cycles > 0 && cyc == hold_cycles) begin
            checks++;
            if (nbytes != 0) begin
               errors++;
               $display("FAIL %s hold_busy: %0d tx_start pulses while busy, required 0", tag, nbytes);
            end
         end
         hold_busy = (cyc < hold_cycles);
         start_v = 1'b0;
         if (!poked && poke_word >= 0 && s_busy && s_addr == 32'(poke_word)) begin
            start_v = 1'b1;
            poked = 1'b1;
         end
         set_start(sel, start_v);
      end
      set_start(sel, 1'b0);
      hold_busy = 1'b0;
      if (!aborted) begin
         checks++;
         if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_pulse: %0d done pulses after %0d cycles, required 1", tag, ndone, cyc);
         end
         checks++;
         if (nbytes != 4 * depth) begin
            errors++;
            $display("FAIL %s byte_count: %0d bytes, required %0d", tag, nbytes, 4 * depth);
         end
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sel == 0) extra += int'(ifa.tx_start) + int'(ifa.done);
            else          extra += int'(ifb.tx_start) + int'(ifb.done);
         end
         checks++;
         if (extra != 0) begin
            errors++;
            $display("FAIL %s after_done: %0d extra tx_start/done pulses, required 0", tag, extra);
         end
         checks++;
         if ((sel == 0 && (ifa.busy !== 1'b0 || ifa.debug_on !== 1'b0)) ||
             (sel == 1 && (ifb.busy !== 1'b0 || ifb.debug_on !== 1'b0))) begin
            errors++;
            $display("FAIL %s idle_flags: busy/debug_on still high, required 0", tag);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.debug_on !== 1'b0 || ifa.debug_addr !== 32'd0 || ifa.tx_data !== 8'd0 ||
          ifa.tx_start !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_a: on=%b addr=%0h data=%0h start=%b busy=%b done=%b, required all 0",
                  ifa.debug_on, ifa.debug_addr, ifa.tx_data, ifa.tx_start, ifa.busy, ifa.done);
      end
      checks++;
      if (ifb.debug_on !== 1'b0 || ifb.busy !== 1'b0 || ifb.tx_start !== 1'b0 || ifb.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_b: on=%b start=%b busy=%b done=%b, required all 0",
                  ifb.debug_on, ifb.tx_start, ifb.busy, ifb.done);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_dump();
      for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
      mem_a[20] = 32'h0000_0AAA;
      run_dump(0, 0, -1, -1, "full");
   endtask

   task automatic test_preload();
      mem_a[0] = 32'h1122_3344;
      mem_a[1] = 32'h5566_7788;
      mem_a[2] = 32'h99AA_BBCC;
      mem_a[3] = 32'hDDEE_FF00;
      run_dump(0, 0, -1, -1, "preload");
   endtask

   task automatic test_hold_busy();
      run_dump(0, 50, -1, -1, "hold");
   endtask

   task automatic test_start_ignored();
      run_dump(0, 0, 5, -1, "restart");
   endtask

   task automatic test_reset_mid_dump();
      run_dump(0, 0, -1, 42, "midrst");
      repeat (12) @(negedge clk);
      run_dump(0, 0, -1, -1, "after_rst");
   endtask

   task automatic test_rd_lat3();
      mem_b[0] = 32'hA1B2_C3D4;
      mem_b[1] = 32'h0F1E_2D3C;
      mem_b[2] = 32'h1234_5678;
      mem_b[3] = 32'hCAFE_F00D;
      run_dump(1, 0, -1, -1, "lat3");
   endtask

   initial begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      for (int i = 0; i < 32; i++) mem_a[i] = 32'd0;
      for (int i = 0; i < 4; i++) mem_b[i] = 32'd0;
      test_reset();
      test_full_dump();
      test_preload();
      test_hold_busy();
      test_start_ignored();
      test_reset_mid_dump();
      test_rd_lat3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
